// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder that time-shares one full-adder cell over WIDTH cycles
module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sr, b_sr, work;
  logic [CNT_W-1:0] cnt;
  logic carry, c_msb, fa_s, fa_c, last, accept, step;
  assign fa_s = a_sr[0] ^ b_sr[0] ^ carry;
  assign fa_c = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
  assign last = cnt == CNT_W'(WIDTH - 1);
  assign accept = state != RUN && start;
  assign step = state == RUN && !abort;
  assign ready = state != RUN;
  assign busy = state == RUN;
  assign done = state == DONE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == RUN ? (abort ? IDLE : last ? DONE : RUN) : start ? RUN : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr <= '0;
      b_sr <= '0;
      work <= '0;
      carry <= 1'b0;
      c_msb <= 1'b0;
      cnt <= '0;
      sum <= '0;
      cout <= 1'b0;
      ovf <= 1'b0;
    end else if (accept) begin
      a_sr <= op_a;
      b_sr <= op_b;
      carry <= cin;
      cnt <= '0;
    end else if (step) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      work <= {fa_s, work[WIDTH-1:1]};
      carry <= fa_c;
      cnt <= cnt + CNT_W'(1);
      if (cnt == CNT_W'(WIDTH - 2)) c_msb <= fa_c;
      if (last) begin
        sum <= {fa_s, work[WIDTH-1:1]};
        cout <= fa_c;
        ovf <= c_msb ^ fa_c;
      end
    end
  end
endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller. A single 1-bit full-adder cell (sum = a^b^c, carry = majority(a,b,c)) is sequenced over WIDTH cycles, LSB first, to add two WIDTH-bit operands.
- Provides a start/ready/done handshake, a carry register, operand shift registers and a result register that holds its value between operations.
- Intended for area-constrained arithmetic where one full-adder cell is shared in time instead of replicated.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH+1), bit-counter width; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new addition; sampled only when ready=1
- abort  input  1  cancel an in-flight addition; sampled only in RUN
- op_a  input  WIDTH  operand A; captured on accepted start
- op_b  input  WIDTH  operand B; captured on accepted start
- cin  input  1  carry-in; captured on accepted start
- ready  output  1  controller can accept start this cycle
- busy  output  1  addition in progress
- done  output  1  one-cycle completion pulse; sum/cout/ovf valid
- sum  output  WIDTH  registered result
- cout  output  1  registered carry-out of MSB
- ovf  output  1  registered signed overflow (carry into MSB XOR carry out of MSB)

Behaviour:
- Reset: one clock, asynchronous active-low reset. While rst_n=0:
  - state=IDLE; ready=1; busy=0; done=0; sum=0; cout=0; ovf=0.
  - Shift registers, carry register and counter are cleared.
- Reset mid-operation aborts immediately; no done pulse is generated after release.
- States:
  - IDLE: ready=1, busy=0, done=0.
  - RUN: ready=0, busy=1, done=0.
  - DONE: ready=1, busy=0, done=1.
- IDLE, start=1: capture op_a, op_b and cin into the A shift register, B shift register and carry register; clear counter; go to RUN. IDLE, start=0: stay.
- RUN, each edge (abort=0):
  - Full-adder inputs are a_sr[0], b_sr[0], carry_reg.
  - Sum bit shifts into the working register from the MSB side (right shift), so after WIDTH shifts the LSB result sits in bit 0.
  - carry_reg <= full-adder carry; a_sr and b_sr shift right by 1; counter++.
  - On the edge processing bit WIDTH-2, latch the carry into the MSB in a dedicated register for ovf.
  - When the counter reaches WIDTH-1 on the processing edge (the last bit): sum <= final working value, cout <= final carry, ovf <= carry_into_msb ^ final carry; go to DONE.
- RUN, abort=1: go to IDLE on that edge. No bit is processed. sum/cout/ovf keep their previous values; no done pulse.
- DONE: done=1 for exactly one cycle.
  - start=1: accept new operands exactly as in IDLE and go to RUN (back-to-back operation).
  - start=0: go to IDLE.
- Latency: start accepted at edge E0; done is high in the cycle following edge E(WIDTH). Throughput is one addition per WIDTH+1 cycles when back-to-back.
- start while busy=1 is ignored; it is not queued.
- abort outside RUN is ignored. Simultaneous start and abort in IDLE/DONE: start wins.
- op_a, op_b and cin may change freely after acceptance without affecting the in-flight result.
- sum, cout and ovf change only on the completion edge or on reset; they hold through IDLE, RUN and aborts.
- Arithmetic: result is modulo 2^WIDTH; cout is the unsigned carry; ovf is two's-complement overflow.
- No combinational path from any input to any output; all outputs are registered or derived only from state.

Test Plan:
- WIDTH=8; op_a=0x5A, op_b=0x3C, cin=0; start one cycle:
  - busy=1 for 8 cycles, then done=1 for one cycle.
  - sum=0x96, cout=0, ovf=1.
- op_a=0xFF, op_b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then op_a=0x7F, op_b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
- Back-to-back: hold start=1 through the DONE cycle with new operands 0x10+0x20 -> second done exactly 9 cycles after the first, sum=0x30. Any start pulses during RUN produce no extra done.
- Abort: start 0x01+0x01, assert abort on the 4th RUN cycle -> IDLE next edge, no done, sum still equals the previous result (0x30), ready=1.
- Reset mid-op: drive rst_n=0 asynchronously during RUN -> outputs immediately ready=1, busy=0, done=0, sum=0, cout=0, ovf=0. No done pulse after release; the next start computes correctly.
- Randomised 1000 operations at WIDTH=8 and WIDTH=16, compared against a behavioural model of op_a+op_b+cin (sum, cout, ovf); latency checked on every transaction.
